alu_muldiv: RTL
===============

Name: alu_muldiv

Overview:
Parametrised execute-stage unit: XLEN-wide integer ALU plus iterative RV32M multiply/divide behind a valid/ready handshake. Base ops complete in 1 cycle; M ops iterate 1 bit/cycle. Sits between the ID/EX register and the EX/MEM register; the pipeline stalls on in_ready low and squashes in-flight work with flush.

Parameters:
XLEN, 32, operand/result width (≥8, power of 2)
SHW, $clog2(XLEN), shift-amount bits taken from op_b

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous abort of any accepted/in-flight op
in_valid  input  1  operation offered
in_ready  output  1  unit can accept this cycle
op_a  input  XLEN  operand 1
op_b  input  XLEN  operand 2
alu_op  input  3  base op / M funct3
invert  input  1  base: sub / SRA select; ignored for M
m_op  input  1  1 = M-extension op selected by alu_op
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  XLEN  result
zero  output  1  result == 0
less_than  output  1  SLT/SLTU outcome, else 0
busy  output  1  state == CALC

Behaviour:
- Reset (reset low, async): state IDLE; out_valid, result, zero, less_than, busy all 0; in_ready 0 while reset low, 1 after.
- States: IDLE, CALC, DONE. Accept = in_valid & in_ready.
- in_ready = (IDLE) | (DONE & out_ready); back-to-back base ops sustain 1/cycle.
- Base op (m_op=0), accept -> DONE next cycle, result registered:
  000 add / sub (invert); 001 SLL; 010 SLT signed; 011 SLTU; 100 XOR; 101 SRL / SRA (invert); 110 OR; 111 AND.
  Shift amount = op_b[SHW-1:0]; other op_b bits ignored. SLT/SLTU: result = {XLEN-1 zeros, lt}, less_than = lt; compare from XLEN+1-bit subtraction with proper sign/zero extension (unsigned compare correct for all operands).
  invert has no effect on 001,010,011,100,110,111.
- M op (m_op=1), funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  Accept -> CALC; operands converted to magnitudes plus sign flags; XLEN iterations (shift-add multiply into 2·XLEN accumulator / restoring divide); then sign fix-up cycle -> DONE. Latency accept->out_valid = XLEN+2 cycles.
  MUL = low XLEN of product; MULH* = high XLEN.
  Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op_a. Detected at accept; skips CALC (latency 1).
  Signed overflow (op_a = -2^(XLEN-1), op_b = -1): DIV = op_a, REM = 0; latency 1.
- DONE: out_valid=1; result/zero/less_than held stable until out_ready. zero = (result == 0) for every op. less_than=0 for non-SLT ops.
- DONE & out_ready & no accept -> IDLE; with accept -> DONE (base) or CALC (M).
- flush: highest priority; -> IDLE, out_valid 0 next cycle, in_valid ignored that cycle, iteration counter cleared.
- in_valid while CALC: not accepted (in_ready 0); no operand capture.
- Async reset mid-CALC: all state cleared immediately; no partial result emitted.

Decomposition:
- Package alu_pkg: alu_op_e (ADD..AND), m_op_e (MUL..REMU), state_e (IDLE/CALC/DONE), XLEN default constant.
- One sub-module: muldiv_iter (iterative engine + counter, start/done interface); base ALU combinational inside top.

Test Plan:
- Base ops, XLEN=32: add 5+7 -> 12 after 1 cycle; sub 5-5 -> 0, zero=1; SRA 0x80000000>>4 -> 0xF8000000; SLTU 1<0xFFFFFFFF -> 1, less_than=1.
- Back-to-back: 8 adds with out_ready=1 -> 8 results on consecutive cycles, in_ready never drops.
- MUL/MULH: 0xFFFFFFFF * 2 -> MUL 0xFFFFFFFE, MULH 0xFFFFFFFF, MULHU 0x00000001; out_valid exactly 34 cycles after accept.
- Divide corners: DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7, DIV 0x80000000/-1 -> 0x80000000, REM -> 0; DIV -7/2 -> -3, REM -> -1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0, no accepts.
- flush at CALC cycle 10 and async reset at cycle 20 of a DIVU -> IDLE, out_valid 0, next op correct; repeat at XLEN=16.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared opcode, state and width definitions for the
// execute-stage ALU / iterative mul-div unit.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SR,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    M_MUL,
    M_MULH,
    M_MULHSU,
    M_MULHU,
    M_DIV,
    M_DIVU,
    M_REM,
    M_REMU
  } m_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M engine: shift-add multiply and restoring
// divide, one bit per cycle, then a combinational sign fix-up.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CW   = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_RUN  = 2'd1;
  localparam logic [1:0] E_FIX  = 2'd2;

  logic [1:0]        phase;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   mag_b;
  logic [2:0]        fn;
  logic              neg_q;
  logic              neg_r;

  logic              a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b, addend;
  logic [XLEN:0]     sum, trial;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn = op[2] ? ~op[0] : ~op[1];
    sa    = a_sgn & a[XLEN-1];
    sb    = b_sgn & b[XLEN-1];
    abs_a = sa ? (~a + 1'b1) : a;
    abs_b = sb ? (~b + 1'b1) : b;
  end

  // Multiplier sits in the low half and drains out as the product
  // shifts in; divide shifts the dividend up into the remainder half.
  always_comb begin
    addend  = acc[0] ? mag_b : '0;
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
    mul_nxt = {sum, acc[XLEN-1:1]};
    trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_b};
    div_nxt = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                          : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    prod = neg_q ? (~acc + 1'b1) : acc;
    quo  = acc[XLEN-1:0];
    rem  = acc[2*XLEN-1:XLEN];
    if (fn[2]) begin
      if (fn[1]) res = neg_r ? (~rem + 1'b1) : rem;
      else       res = neg_q ? (~quo + 1'b1) : quo;
    end else begin
      if (fn[1:0] == 2'b00) res = prod[XLEN-1:0];
      else                  res = prod[2*XLEN-1:XLEN];
    end
  end

  assign done = (phase == E_FIX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= E_IDLE;
      cnt   <= '0;
      acc   <= '0;
      mag_b <= '0;
      fn    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (kill) begin
      phase <= E_IDLE;
      cnt   <= '0;
    end else if (start) begin
      phase <= E_RUN;
      cnt   <= '0;
      acc   <= {{XLEN{1'b0}}, abs_a};
      mag_b <= abs_b;
      fn    <= op;
      neg_q <= sa ^ sb;
      neg_r <= sa;
    end else begin
      case (phase)
        E_RUN: begin
          acc <= fn[2] ? div_nxt : mul_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN - 1)) phase <= E_FIX;
        end
        E_FIX:   phase <= E_IDLE;
        default: phase <= E_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage unit: single-cycle integer ALU plus iterative
// multiply/divide behind a valid/ready handshake.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      alu_op,
  input  logic            invert,
  input  logic            m_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less_than,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic            accept, start, special;
  logic            b_zero, ovf, cmp_s, lt_op, alu_lt;
  logic            iter_done;
  logic [XLEN-1:0] alu_res, sp_res, iter_res;
  logic [XLEN-1:0] b_eff, sum;
  logic [XLEN:0]   cmp_diff;
  logic [SHW-1:0]  shamt;

  assign in_ready  = reset & ((state == IDLE) |
                     ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);

  always_comb begin
    b_eff    = invert ? ~op_b : op_b;
    sum      = op_a + b_eff + {{(XLEN-1){1'b0}}, invert};
    shamt    = op_b[SHW-1:0];
    cmp_s    = (alu_op == ALU_SLT);
    lt_op    = (alu_op == ALU_SLT) | (alu_op == ALU_SLTU);
    cmp_diff = {cmp_s & op_a[XLEN-1], op_a} -
               {cmp_s & op_b[XLEN-1], op_b};
    alu_lt   = cmp_diff[XLEN];
    alu_res  = '0;
    unique case (alu_op_e'(alu_op))
      ALU_ADD:  alu_res = sum;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, alu_lt};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, alu_lt};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SR: begin
        if (invert) alu_res = $signed(op_a) >>> shamt;
        else        alu_res = op_a >> shamt;
      end
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  // Divide corner cases resolve at accept and never enter CALC.
  always_comb begin
    b_zero  = (op_b == '0);
    ovf     = ~alu_op[0] & (&op_b) &
              (op_a == {1'b1, {(XLEN-1){1'b0}}});
    special = m_op & alu_op[2] & (b_zero | ovf);
    sp_res  = '0;
    unique case (1'b1)
      b_zero:  sp_res = alu_op[1] ? op_a : '1;
      ovf:     sp_res = alu_op[1] ? '0 : op_a;
      default: sp_res = '0;
    endcase
  end

  assign start = accept & m_op & ~special;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk   (clk),
    .reset (reset),
    .kill  (flush),
    .start (start),
    .op    (alu_op),
    .a     (op_a),
    .b     (op_b),
    .done  (iter_done),
    .res   (iter_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      result    <= '0;
      zero      <= 1'b0;
      less_than <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      if (!m_op) begin
        state     <= DONE;
        result    <= alu_res;
        zero      <= (alu_res == '0);
        less_than <= lt_op & alu_lt;
      end else if (special) begin
        state     <= DONE;
        result    <= sp_res;
        zero      <= (sp_res == '0);
        less_than <= 1'b0;
      end else begin
        state <= CALC;
      end
    end else if ((state == CALC) && iter_done) begin
      state     <= DONE;
      result    <= iter_res;
      zero      <= (iter_res == '0);
      less_than <= 1'b0;
    end else if ((state == DONE) && out_ready) begin
      state <= IDLE;
    end
  end

endmodule
